add8u_err_monitor: RTL and testbench
====================================

# add8u_err_monitor

Sequential error-characterisation engine for 8-bit unsigned approximate adders. It consumes a stream of operand pairs and the candidate adder's 9-bit result, computes the exact sum internally, and accumulates error statistics over a fixed sample count. Reported statistics are sum of absolute error, worst-case error, error count and sum of squared error. It sits on the evaluation/FPGA-characterisation side of the library, downstream of any add8u candidate under test.

## Interface

Parameters:

- N_SAMPLES, 65536: number of accepted beats per measurement run; must be ≥ 1 and ≤ 2^CNT_W − 1.
- CNT_W, 17: width of the sample counter and err_cnt.

Ports:

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE and is ignored otherwise.
- s_valid  in  1  operand/result beat valid.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- a  in  8  operand A.
- b  in  8  operand B.
- o  in  9  approximate sum from the candidate.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results are stable while high.
- err_sum  out  CNT_W+9  Σ|o − (a+b)|.
- err_max  out  9  max |o − (a+b)|, the worst-case error.
- err_cnt  out  CNT_W  number of beats with nonzero error.
- sq_sum  out  CNT_W+18  Σ(o − (a+b))².

## Operation

- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start.
  - RUN → DRAIN on the cycle the N_SAMPLES-th beat is accepted.
  - DRAIN → DONE after 2 cycles, once the pipeline is empty.
  - DONE → RUN on start.
- **On entering RUN:** all accumulators, err_max and the sample counter clear to 0 in the same cycle.
- **s_ready:** high only in RUN. It drops combinationally low once the accepted count reaches N_SAMPLES, so no beat N_SAMPLES+1 is ever taken.
- **Stage 1** (registered on accept):
  - exact = {1'b0,a} + {1'b0,b}, 9 bits, never overflows.
  - d = o − exact, 10-bit signed.
  - e = |d|, 9 bits, max 511.
  - Stage-1 valid flag set.
- **Stage 2** (registered when the stage-1 valid flag is set):
  - err_sum += e.
  - sq_sum += e*e, an 18-bit product.
  - err_cnt += (e != 0).
  - err_max = max(err_max, e).
- Accumulator widths are sized so no wrap is possible for N_SAMPLES ≤ 2^CNT_W − 1. No saturation logic is required.
- **Output hold:** outputs reflect live accumulators at all times, but are meaningful only while done = 1. They hold their values in DONE until the next start.
- **start while busy:** start during RUN or DRAIN is ignored, and the run is not restarted.
- **s_valid outside RUN:** s_valid while s_ready = 0 is ignored, with no side effects.

## Timing

- **Reset values:** state = IDLE, s_ready = 0, busy = 0, done = 0, all statistics outputs = 0, pipeline valid flags = 0.
- **Reset mid-run:** reset asserted mid-run aborts immediately to the reset values. Partial results are discarded.
- **Acceptance rate:** one beat per cycle maximum. Gaps in s_valid stall the count but do not flush the pipeline; in-flight beats still complete.
- **Latency:** a beat accepted at edge k is reflected in the statistics after edge k+2.
- **Last beat:** if the last beat is accepted at edge k, then busy falls and done rises after edge k+2, with final statistics valid in that same cycle.
- **Start to ready:** start sampled at edge k makes s_ready = 1 from the cycle after edge k. A beat presented in the same cycle as start is not accepted.
- **Restart from DONE:** start in DONE clears done and the results at the same edge that enters RUN.

## Test plan

- **Exact model:** N_SAMPLES = 256, beats with o = a+b, random a/b → done; err_sum = 0, err_max = 0, err_cnt = 0, sq_sum = 0.
- **Single beat:** N_SAMPLES = 1, a = 3, b = 1, o = 0 → err_sum = 4, err_max = 4, err_cnt = 1, sq_sum = 16; done exactly 2 cycles after the accept edge.
- **Exhaustive approximate model:** N_SAMPLES = 65536, all (a,b) pairs. The model has o[1:0] = b[1:0], carry into bit 2 = a[1], and exact ripple above → err_sum = 65536 (MAE 1.0), err_max = 2, err_cnt = 49152 (EP 75%), sq_sum = 98304 (MSE 1.5).
- **Backpressure and bounds:** N_SAMPLES = 4, s_valid toggling 1,0,1,1,0,1,1 with o = a+b+1 → exactly 4 beats counted, err_sum = 4; s_ready low after the 4th accept; the 5th presented beat is ignored.
- **Reset and restart:** rst pulsed after 10 of 20 beats → all outputs 0 and state IDLE. Then start during RUN is ignored. Then start in DONE clears prior results to 0 before the new accumulation.
- **Max error:** a = 255, b = 255, o = 0 → e = 510, err_max = 510, sq_sum = 260100.

Source files
------------

// File: rtl/add8u_err_monitor.sv
// add8u_err_monitor
// Error-characterisation engine for 8-bit unsigned approximate adders.
// Each accepted beat carries operands a/b and the candidate's 9-bit sum o.
// A two-stage pipeline computes |o - (a+b)| and folds it into four
// statistics over N_SAMPLES beats:
//   - sum of absolute error
//   - worst-case error
//   - count of erroneous beats
//   - sum of squared error
// A final output register stage makes a beat accepted at edge k visible
// after edge k+2. That is the same edge on which done rises for the last beat.

module add8u_err_monitor #(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic [8:0]         o,
  output logic               busy,
  output logic               done,
  output logic [CNT_W+8:0]   err_sum,
  output logic [8:0]         err_max,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W+17:0]  sq_sum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Beat-count thresholds in counter width.
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES - 1);

  // Absolute error of one beat.
  // The exact sum is 9 bits and cannot overflow. The signed difference needs
  // 10 bits, covering -510 .. +511.
  function automatic logic [8:0] abs_err(input logic [7:0] a_v,
                                         input logic [7:0] b_v,
                                         input logic [8:0] o_v);
    logic [8:0] exact_v;
    logic [9:0] d_v;
    exact_v = {1'b0, a_v} + {1'b0, b_v};
    d_v     = {1'b0, o_v} - {1'b0, exact_v};
    if (d_v[9]) begin
      abs_err = 9'(10'd0 - d_v);
    end else begin
      abs_err = d_v[8:0];
    end
  endfunction

  // Control state.
  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic             drain_q;
  logic [CNT_W-1:0] cnt_q;

  // Stage 1: per-beat absolute error.
  logic             s1_vld_q;
  logic [8:0]       s1_e_q;

  // Stage 2: live accumulators.
  logic [CNT_W+8:0]  acc_sum_q,  acc_sum_d;
  logic [8:0]        acc_max_q,  acc_max_d;
  logic [CNT_W-1:0]  acc_cnt_q,  acc_cnt_d;
  logic [CNT_W+17:0] acc_sq_q,   acc_sq_d;

  // Output register stage.
  logic [CNT_W+8:0]  out_sum_q;
  logic [8:0]        out_max_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [CNT_W+17:0] out_sq_q;

  logic             start_run_s;
  logic             accept_s;
  logic [8:0]       e_s;
  logic [17:0]      sq_s;

  // A start is honoured only from IDLE or DONE; a start during RUN or DRAIN
  // never restarts the run.
  assign start_run_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Ready is combinational so that beat N_SAMPLES+1 can never be taken.
  assign s_ready  = (state_q == S_RUN) && (cnt_q != N_FULL);
  assign accept_s = s_valid && s_ready;
  assign e_s      = abs_err(a, b, o);
  assign sq_s     = {9'd0, s1_e_q} * {9'd0, s1_e_q};

  // Run-control FSM.
  // The sample counter, busy and done are updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drain_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            drain_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (accept_s) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == N_LAST) begin
              state_q <= S_DRAIN;
              drain_q <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Two cycles: one to accumulate the last beat, one to register it.
          if (drain_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            drain_q <= 1'b0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          drain_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Stage 1: capture the absolute error of each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_e_q   <= 9'd0;
    end else if (start_run_s) begin
      s1_vld_q <= 1'b0;
      s1_e_q   <= 9'd0;
    end else begin
      s1_vld_q <= accept_s;
      if (accept_s) begin
        s1_e_q <= e_s;
      end
    end
  end

  // Next accumulator values.
  // All widths are sized so that no wrap occurs within one run.
  always_comb begin
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    acc_cnt_d = acc_cnt_q;
    acc_sq_d  = acc_sq_q;
    if (s1_vld_q) begin
      acc_sum_d = acc_sum_q + {{CNT_W{1'b0}}, s1_e_q};
      acc_sq_d  = acc_sq_q + {{CNT_W{1'b0}}, sq_s};
      if (s1_e_q != 9'd0) begin
        acc_cnt_d = acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        acc_cnt_d = acc_cnt_q;
      end
      if (s1_e_q > acc_max_q) begin
        acc_max_d = s1_e_q;
      end else begin
        acc_max_d = acc_max_q;
      end
    end else begin
      acc_sum_d = acc_sum_q;
    end
  end

  // Stage 2: accumulators, cleared on the edge that enters RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_q <= '0;
      acc_max_q <= 9'd0;
      acc_cnt_q <= '0;
      acc_sq_q  <= '0;
    end else if (start_run_s) begin
      acc_sum_q <= '0;
      acc_max_q <= 9'd0;
      acc_cnt_q <= '0;
      acc_sq_q  <= '0;
    end else begin
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      acc_cnt_q <= acc_cnt_d;
      acc_sq_q  <= acc_sq_d;
    end
  end

  // Output registers track the accumulators.
  // They clear together with them on restart, so stale results never show
  // once a new run begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum_q <= '0;
      out_max_q <= 9'd0;
      out_cnt_q <= '0;
      out_sq_q  <= '0;
    end else if (start_run_s) begin
      out_sum_q <= '0;
      out_max_q <= 9'd0;
      out_cnt_q <= '0;
      out_sq_q  <= '0;
    end else begin
      out_sum_q <= acc_sum_q;
      out_max_q <= acc_max_q;
      out_cnt_q <= acc_cnt_q;
      out_sq_q  <= acc_sq_q;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_sum = out_sum_q;
  assign err_max = out_max_q;
  assign err_cnt = out_cnt_q;
  assign sq_sum  = out_sq_q;

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Directed bench for add8u_err_monitor.
// Five instances with different sample counts share the beat inputs.
// Each instance has its own start, and only the started instance is in RUN
// at any time.

module tb_add8u_err_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] a, b;
  logic [8:0] o;
  logic       start1, start4, start20, start256, startx;

  logic rdy1, busy1, done1;
  logic rdy4, busy4, done4;
  logic rdy20, busy20, done20;
  logic rdy256, busy256, done256;
  logic rdyx, busyx, donex;

  logic [25:0] sum1, sum4, sum20, sum256, sumx;
  logic [8:0]  max1, max4, max20, max256, maxx;
  logic [16:0] cnt1, cnt4, cnt20, cnt256, cntx;
  logic [34:0] sq1, sq4, sq20, sq256, sqx;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] pat;
  logic [6:0] up;

  always #5 clk = ~clk;

  add8u_err_monitor #(.N_SAMPLES(1), .CNT_W(17)) u1 (
    .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid), .s_ready(rdy1),
    .a(a), .b(b), .o(o), .busy(busy1), .done(done1),
    .err_sum(sum1), .err_max(max1), .err_cnt(cnt1), .sq_sum(sq1));

  add8u_err_monitor #(.N_SAMPLES(4), .CNT_W(17)) u4 (
    .clk(clk), .rst(rst), .start(start4), .s_valid(s_valid), .s_ready(rdy4),
    .a(a), .b(b), .o(o), .busy(busy4), .done(done4),
    .err_sum(sum4), .err_max(max4), .err_cnt(cnt4), .sq_sum(sq4));

  add8u_err_monitor #(.N_SAMPLES(20), .CNT_W(17)) u20 (
    .clk(clk), .rst(rst), .start(start20), .s_valid(s_valid), .s_ready(rdy20),
    .a(a), .b(b), .o(o), .busy(busy20), .done(done20),
    .err_sum(sum20), .err_max(max20), .err_cnt(cnt20), .sq_sum(sq20));

  add8u_err_monitor #(.N_SAMPLES(256), .CNT_W(17)) u256 (
    .clk(clk), .rst(rst), .start(start256), .s_valid(s_valid), .s_ready(rdy256),
    .a(a), .b(b), .o(o), .busy(busy256), .done(done256),
    .err_sum(sum256), .err_max(max256), .err_cnt(cnt256), .sq_sum(sq256));

  add8u_err_monitor #(.N_SAMPLES(65536), .CNT_W(17)) ux (
    .clk(clk), .rst(rst), .start(startx), .s_valid(s_valid), .s_ready(rdyx),
    .a(a), .b(b), .o(o), .busy(busyx), .done(donex),
    .err_sum(sumx), .err_max(maxx), .err_cnt(cntx), .sq_sum(sqx));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; a = 8'd0; b = 8'd0; o = 9'd0;
    start1 = 1'b0; start4 = 1'b0; start20 = 1'b0; start256 = 1'b0; startx = 1'b0;
    pat = 7'b1101101;
    up  = 7'd0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_ready",  64'(rdy1),  64'd0);
    chk("rst_busy",   64'(busy1), 64'd0);
    chk("rst_done",   64'(done1), 64'd0);
    chk("rst_sum",    64'(sum20), 64'd0);
    chk("rst_max",    64'(max20), 64'd0);
    chk("rst_cnt",    64'(cnt20), 64'd0);
    chk("rst_sq",     64'(sq20),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat: the beat presented alongside start must not be taken
    start1 = 1'b1; s_valid = 1'b1; a = 8'd3; b = 8'd1; o = 9'd0;
    @(negedge clk);
    start1 = 1'b0;
    chk("one_ready_after_start", 64'(rdy1),  64'd1);
    chk("one_busy",              64'(busy1), 64'd1);
    @(negedge clk);                      // accept edge k passed
    s_valid = 1'b0;
    chk("one_ready_low", 64'(rdy1), 64'd0);
    chk("one_done_k0",   64'(done1), 64'd0);
    @(negedge clk);                      // after k+1
    chk("one_done_k1",   64'(done1), 64'd0);
    chk("one_busy_k1",   64'(busy1), 64'd1);
    @(negedge clk);                      // after k+2
    chk("one_done_k2",   64'(done1), 64'd1);
    chk("one_busy_k2",   64'(busy1), 64'd0);
    chk("one_sum",       64'(sum1),  64'd4);
    chk("one_max",       64'(max1),  64'd4);
    chk("one_cnt",       64'(cnt1),  64'd1);
    chk("one_sq",        64'(sq1),   64'd16);

    // Max error, also a restart from DONE on u1
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("max_restart_done", 64'(done1), 64'd0);
    chk("max_restart_sum",  64'(sum1),  64'd0);
    s_valid = 1'b1; a = 8'd255; b = 8'd255; o = 9'd0;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("max_done", 64'(done1), 64'd1);
    chk("max_sum",  64'(sum1),  64'd510);
    chk("max_max",  64'(max1),  64'd510);
    chk("max_cnt",  64'(cnt1),  64'd1);
    chk("max_sq",   64'(sq1),   64'd260100);

    // Backpressure and bounds with u4, error of +1 on every beat
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = pat[i];
      a = 8'(i * 7 + 5);
      b = 8'(i * 3);
      o = 9'({1'b0, a} + {1'b0, b} + 9'd1);
      if (i == 4) chk("bp_ready_mid", 64'(rdy4), 64'd1);
      if (i == 6) chk("bp_ready_after4", 64'(rdy4), 64'd0);
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("bp_done_k1", 64'(done4), 64'd0);
    @(negedge clk);
    chk("bp_done", 64'(done4), 64'd1);
    chk("bp_sum",  64'(sum4),  64'd4);
    chk("bp_cnt",  64'(cnt4),  64'd4);
    chk("bp_max",  64'(max4),  64'd1);
    chk("bp_sq",   64'(sq4),   64'd4);

    // Reset mid-run on u20 after 10 of 20 beats
    start20 = 1'b1;
    @(negedge clk);
    start20 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      a = 8'(i * 9); b = 8'(i * 4 + 7);
      o = 9'({1'b0, a} + {1'b0, b} + 9'd2);
      @(negedge clk);
    end
    chk("mid_busy_before_rst", 64'(busy20), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy",  64'(busy20), 64'd0);
    chk("mid_rst_ready", 64'(rdy20),  64'd0);
    chk("mid_rst_sum",   64'(sum20),  64'd0);
    chk("mid_rst_max",   64'(max20),  64'd0);
    chk("mid_rst_cnt",   64'(cnt20),  64'd0);
    chk("mid_rst_sq",    64'(sq20),   64'd0);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("mid_idle_busy", 64'(busy20), 64'd0);
    chk("mid_idle_done", 64'(done20), 64'd0);
    chk("mid_idle_sum",  64'(sum20),  64'd0);

    // Full 20-beat run with start pulsed in the middle (must be ignored)
    start20 = 1'b1;
    @(negedge clk);
    start20 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      start20 = (i == 10) ? 1'b1 : 1'b0;
      a = 8'(i * 9); b = 8'(i * 4 + 7);
      o = 9'({1'b0, a} + {1'b0, b} + 9'd3);
      @(negedge clk);
    end
    s_valid = 1'b0; start20 = 1'b0;
    chk("ign_busy_k0", 64'(busy20), 64'd1);
    repeat (2) @(negedge clk);
    chk("ign_done", 64'(done20), 64'd1);
    chk("ign_sum",  64'(sum20),  64'd60);
    chk("ign_max",  64'(max20),  64'd3);
    chk("ign_cnt",  64'(cnt20),  64'd20);
    chk("ign_sq",   64'(sq20),   64'd180);
    repeat (3) @(negedge clk);
    chk("hold_sum", 64'(sum20),  64'd60);
    chk("hold_done", 64'(done20), 64'd1);

    // Restart from DONE clears results before the new accumulation
    start20 = 1'b1;
    @(negedge clk);
    start20 = 1'b0;
    chk("rs_done", 64'(done20), 64'd0);
    chk("rs_busy", 64'(busy20), 64'd1);
    chk("rs_sum",  64'(sum20),  64'd0);
    chk("rs_max",  64'(max20),  64'd0);
    chk("rs_cnt",  64'(cnt20),  64'd0);
    chk("rs_sq",   64'(sq20),   64'd0);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      a = 8'(i * 5); b = 8'(i * 6 + 1);
      o = 9'({1'b0, a} + {1'b0, b} + 9'd1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rs2_done", 64'(done20), 64'd1);
    chk("rs2_sum",  64'(sum20),  64'd20);
    chk("rs2_max",  64'(max20),  64'd1);
    chk("rs2_sq",   64'(sq20),   64'd20);

    // Exact model, 256 random beats
    start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      o = {1'b0, a} + {1'b0, b};
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ex_done", 64'(done256), 64'd1);
    chk("ex_sum",  64'(sum256),  64'd0);
    chk("ex_max",  64'(max256),  64'd0);
    chk("ex_cnt",  64'(cnt256),  64'd0);
    chk("ex_sq",   64'(sq256),   64'd0);

    // Exhaustive approximate model: o[1:0] = b[1:0], carry-in to bit 2 = a[1]
    startx = 1'b1;
    @(negedge clk);
    startx = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      s_valid = 1'b1;
      a = 8'(i >> 8);
      b = 8'(i & 255);
      up = {1'b0, a[7:2]} + {1'b0, b[7:2]} + {6'd0, a[1]};
      o = {up, b[1:0]};
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("ax_done_k0", 64'(donex), 64'd0);
    repeat (2) @(negedge clk);
    chk("ax_done", 64'(donex), 64'd1);
    chk("ax_sum",  64'(sumx),  64'd65536);
    chk("ax_max",  64'(maxx),  64'd2);
    chk("ax_cnt",  64'(cntx),  64'd49152);
    chk("ax_sq",   64'(sqx),   64'd98304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
